// File: rtl/instruction_decode_stage.sv
// RV32I decode stage: register file with write-through bypass, control decoder,
// immediate extender and the ID/EX pipeline register.
module instruction_decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE
);

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J} imm_sel_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] rd1, rd2, imm_ext;
  logic            reg_write, mem_write, jump, branch, alu_src;
  logic [1:0]      result_src;
  logic [2:0]      alu_control;
  logic [2:0]      alu_funct;
  imm_sel_t        imm_sel;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            wr_en;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign Rs1D   = InstrD[19:15];
  assign Rs2D   = InstrD[24:20];
  assign wr_en  = RegWriteW && (RdW != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[RdW] <= ResultW;
    end
  end

  // Bypass lets an instruction in D see the value being written back this cycle.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (Rs1D != '0) rd1 = (wr_en && RdW == Rs1D) ? ResultW : regs[Rs1D];
    if (Rs2D != '0) rd2 = (wr_en && RdW == Rs2D) ? ResultW : regs[Rs2D];
  end

  always_comb begin
    unique case (funct3)
      3'b000:  alu_funct = (opcode == OP_R && InstrD[30]) ? 3'b001 : 3'b000;
      3'b010:  alu_funct = 3'b101;
      3'b110:  alu_funct = 3'b011;
      3'b111:  alu_funct = 3'b010;
      default: alu_funct = 3'b000;
    endcase
  end

  always_comb begin
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    jump        = 1'b0;
    branch      = 1'b0;
    alu_src     = 1'b0;
    result_src  = 2'b00;
    alu_control = 3'b000;
    imm_sel     = IMM_NONE;
    case (opcode)
      OP_LW: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = 2'b01;
        imm_sel    = IMM_I;
      end
      OP_SW: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        imm_sel   = IMM_S;
      end
      OP_R: begin
        reg_write   = 1'b1;
        alu_control = alu_funct;
      end
      OP_IALU: begin
        reg_write   = 1'b1;
        alu_src     = 1'b1;
        imm_sel     = IMM_I;
        alu_control = alu_funct;
      end
      OP_BEQ: begin
        branch      = 1'b1;
        imm_sel     = IMM_B;
        alu_control = 3'b001;
      end
      OP_JAL: begin
        reg_write  = 1'b1;
        jump       = 1'b1;
        result_src = 2'b10;
        imm_sel    = IMM_J;
      end
      default: ;
    endcase
  end

  always_comb begin
    imm_ext = '0;
    case (imm_sel)
      IMM_I: imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
      IMM_S: imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B: imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25],
                        InstrD[11:8], 1'b0};
      IMM_J: imm_ext = {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20],
                        InstrD[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || FlushE) begin
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= '0;
      ALUControlE <= '0;
    end else begin
      RD1E        <= rd1;
      RD2E        <= rd2;
      ImmExtE     <= imm_ext;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      RdE         <= InstrD[11:7];
      RegWriteE   <= reg_write;
      MemWriteE   <= mem_write;
      JumpE       <= jump;
      BranchE     <= branch;
      ALUSrcE     <= alu_src;
      ResultSrcE  <= result_src;
      ALUControlE <= alu_control;
    end
  end

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Self-checking bench for instruction_decode_stage against an ISA-level reference model.
module tb_instruction_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW, FlushE;
  logic [4:0]  RdW;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;

  int errors = 0;
  int checks = 0;

  logic [31:0]  mregs [32];
  logic [184:0] exp_e;
  logic [184:0] obs;
  logic [9:0]   ctl;

  assign obs = {RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE,
                RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE};
  assign ctl = {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE};

  instruction_decode_stage #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .FlushE(FlushE),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE)
  );

  always #5 clk = ~clk;

  // Architectural read value of register idx, seeing a concurrent write-back.
  function automatic logic [31:0] rdval(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (RegWriteW && RdW == idx) return ResultW;
    return mregs[idx];
  endfunction

  function automatic logic [184:0] model_e(input logic [31:0] ins, input logic [31:0] pc,
                                           input logic [31:0] r1, input logic [31:0] r2);
    logic [6:0] op;
    logic [2:0] f3;
    logic signed [31:0] t;
    logic [31:0] imm;
    logic rw, mw, j, b, as;
    logic [1:0] rs;
    logic [2:0] alu, fa;
    op = ins[6:0];
    f3 = ins[14:12];
    imm = 0; rw = 0; mw = 0; j = 0; b = 0; as = 0; rs = 0; alu = 0;
    case (f3)
      3'd0:    fa = (op == 7'h33 && ins[30]) ? 3'd1 : 3'd0;
      3'd2:    fa = 3'd5;
      3'd6:    fa = 3'd3;
      3'd7:    fa = 3'd2;
      default: fa = 3'd0;
    endcase
    case (op)
      7'h03: begin rw = 1; as = 1; rs = 2'd1; t = ins; imm = t >>> 20; end
      7'h23: begin mw = 1; as = 1; t = {ins[31:25], ins[11:7], 20'd0}; imm = t >>> 20; end
      7'h33: begin rw = 1; alu = fa; end
      7'h13: begin rw = 1; as = 1; alu = fa; t = ins; imm = t >>> 20; end
      7'h63: begin
        b = 1; alu = 3'd1;
        t = {ins[31], ins[7], ins[30:25], ins[11:8], 20'd0}; imm = t >>> 19;
      end
      7'h6F: begin
        rw = 1; j = 1; rs = 2'd2;
        t = {ins[31], ins[19:12], ins[20], ins[30:21], 12'd0}; imm = t >>> 11;
      end
      default: ;
    endcase
    return {r1, r2, imm, pc, pc + 32'd4, ins[19:15], ins[24:20], ins[11:7],
            rw, mw, j, b, as, rs, alu};
  endfunction

  // Apply one cycle of stimulus, predict the ID/EX contents, advance past the edge.
  task automatic drive_edge(input logic [31:0] ins, input logic [31:0] pc, input logic wen,
                            input logic [4:0] wd, input logic [31:0] wdata, input logic flush);
    InstrD = ins; PCD = pc; PCPlus4D = pc + 32'd4;
    RegWriteW = wen; RdW = wd; ResultW = wdata; FlushE = flush;
    #0;
    exp_e = flush ? '0 : model_e(ins, pc, rdval(ins[19:15]), rdval(ins[24:20]));
    @(posedge clk); #1;
    if (wen && wd != 5'd0) mregs[wd] = wdata;
  endtask

  task automatic test_reset;
    rst = 0; InstrD = 32'h0031E233; PCD = 32'h100; PCPlus4D = 32'h104;
    RegWriteW = 1; RdW = 5'd7; ResultW = 32'h55; FlushE = 0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    #3;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_initial got %h want 0", obs); end
    @(posedge clk); #1;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_held got %h want 0", obs); end
    rst = 1;
  endtask

  task automatic test_writeback_read;
    drive_edge(32'h0, 32'h0, 1'b1, 5'd5, 32'h12345678, 1'b0);
    drive_edge(32'h000280B3, 32'h200, 1'b0, 5'd0, 32'h0, 1'b0);
    checks++;
    if (obs !== exp_e) begin errors++; $display("FAIL wb_read_model got %h want %h", obs, exp_e); end
    checks++;
    if ({RD1E, RD2E, ALUControlE, RegWriteE, RdE} !== {32'h12345678, 32'h0, 3'd0, 1'b1, 5'd1}) begin
      errors++;
      $display("FAIL wb_read_fields rd1=%h rd2=%h alu=%0d rw=%b rd=%0d want 12345678 0 0 1 1",
               RD1E, RD2E, ALUControlE, RegWriteE, RdE);
    end
  endtask

  task automatic test_bypass;
    drive_edge(32'h0031E233, 32'h204, 1'b1, 5'd3, 32'hAA, 1'b0);
    checks++;
    if (RD1E !== 32'hAA || RD2E !== 32'hAA) begin
      errors++; $display("FAIL bypass rd1=%h rd2=%h want aa aa", RD1E, RD2E);
    end
    checks++;
    if (obs !== exp_e) begin errors++; $display("FAIL bypass_model got %h want %h", obs, exp_e); end
  endtask

  task automatic test_x0;
    drive_edge(32'h000000B3, 32'h208, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
    checks++;
    if (RD1E !== 32'h0) begin errors++; $display("FAIL x0_bypass rd1=%h want 0", RD1E); end
    drive_edge(32'h000000B3, 32'h20C, 1'b0, 5'd0, 32'h0, 1'b0);
    checks++;
    if (RD1E !== 32'h0 || RD2E !== 32'h0) begin
      errors++; $display("FAIL x0_read rd1=%h rd2=%h want 0 0", RD1E, RD2E);
    end
  endtask

  task automatic test_imm;
    drive_edge(32'hFFC00093, 32'h210, 1'b0, 5'd0, 32'h0, 1'b0);
    checks++;
    if ({ImmExtE, ALUSrcE, ALUControlE} !== {32'hFFFFFFFC, 1'b1, 3'd0}) begin
      errors++; $display("FAIL imm_addi imm=%h as=%b alu=%0d want fffffffc 1 0", ImmExtE, ALUSrcE, ALUControlE);
    end
    drive_edge(32'hFE000EE3, 32'h214, 1'b0, 5'd0, 32'h0, 1'b0);
    checks++;
    if ({ImmExtE, BranchE, ALUControlE} !== {32'hFFFFFFFC, 1'b1, 3'd1}) begin
      errors++; $display("FAIL imm_beq imm=%h br=%b alu=%0d want fffffffc 1 1", ImmExtE, BranchE, ALUControlE);
    end
    drive_edge(32'h008000EF, 32'h218, 1'b0, 5'd0, 32'h0, 1'b0);
    checks++;
    if ({ImmExtE, JumpE, ResultSrcE} !== {32'h8, 1'b1, 2'd2}) begin
      errors++; $display("FAIL imm_jal imm=%h j=%b rs=%0d want 8 1 2", ImmExtE, JumpE, ResultSrcE);
    end
    checks++;
    if (obs !== exp_e) begin errors++; $display("FAIL imm_jal_model got %h want %h", obs, exp_e); end
  endtask

  task automatic test_flush;
    drive_edge(32'h40308133, 32'h21C, 1'b1, 5'd9, 32'hBEEF, 1'b1);
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL flush got %h want 0", obs); end
    drive_edge(32'h40308133, 32'h21C, 1'b0, 5'd0, 32'h0, 1'b0);
    checks++;
    if (ALUControlE !== 3'd1 || RdE !== 5'd2) begin
      errors++; $display("FAIL after_flush alu=%0d rd=%0d want 1 2", ALUControlE, RdE);
    end
    // the write to x9 during the flushed cycle must have landed
    drive_edge(32'h00048033, 32'h220, 1'b0, 5'd0, 32'h0, 1'b0);
    checks++;
    if (RD1E !== 32'hBEEF) begin errors++; $display("FAIL flush_write rd1=%h want beef", RD1E); end
  endtask

  task automatic test_random;
    logic [6:0] ops [7];
    logic [31:0] ins;
    ops[0] = 7'h03; ops[1] = 7'h23; ops[2] = 7'h33; ops[3] = 7'h13;
    ops[4] = 7'h63; ops[5] = 7'h6F; ops[6] = 7'h00;
    for (int n = 0; n < 300; n++) begin
      ins = $urandom;
      ins[6:0] = (n % 11 == 10) ? 7'($urandom) : ops[$urandom_range(0, 6)];
      if ($urandom_range(0, 3) == 0) ins[19:15] = 5'($urandom_range(0, 3));
      drive_edge(ins, $urandom & 32'hFFFFFFFC, 1'($urandom_range(0, 2) != 0),
                 5'($urandom_range(0, 3) == 0 ? 0 : $urandom), $urandom,
                 ($urandom_range(0, 7) == 0));
      checks++;
      if (obs !== exp_e) begin errors++; $display("FAIL random[%0d] ins=%h got %h want %h", n, ins, obs, exp_e); end
      checks++;
      if (Rs1D !== ins[19:15] || Rs2D !== ins[24:20]) begin
        errors++; $display("FAIL rs_comb[%0d] got %0d %0d want %0d %0d", n, Rs1D, Rs2D, ins[19:15], ins[24:20]);
      end
    end
  endtask

  task automatic test_async_reset;
    drive_edge(32'h0, 32'h0, 1'b1, 5'd5, 32'hCAFE0001, 1'b0);
    drive_edge(32'h0, 32'h0, 1'b1, 5'd3, 32'hCAFE0002, 1'b0);
    drive_edge(32'h003280B3, 32'h300, 1'b0, 5'd0, 32'h0, 1'b0);
    checks++;
    if (RD1E !== 32'hCAFE0001 || RD2E !== 32'hCAFE0002) begin
      errors++; $display("FAIL pre_reset rd1=%h rd2=%h want cafe0001 cafe0002", RD1E, RD2E);
    end
    #3 rst = 0;
    #1;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL async_reset got %h want 0", obs); end
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    @(posedge clk); #1;
    rst = 1;
    drive_edge(32'h003280B3, 32'h304, 1'b0, 5'd0, 32'h0, 1'b0);
    checks++;
    if (RD1E !== 32'h0 || RD2E !== 32'h0) begin
      errors++; $display("FAIL regs_cleared rd1=%h rd2=%h want 0 0", RD1E, RD2E);
    end
    checks++;
    if (obs !== exp_e) begin errors++; $display("FAIL post_reset_model got %h want %h", obs, exp_e); end
    drive_edge(32'h0000007F, 32'h308, 1'b0, 5'd0, 32'h0, 1'b0);
    checks++;
    if (ctl !== '0 || ImmExtE !== 32'h0) begin
      errors++; $display("FAIL unknown_op ctl=%h imm=%h want 0 0", ctl, ImmExtE);
    end
    checks++;
    if (obs !== exp_e) begin errors++; $display("FAIL unknown_op_model got %h want %h", obs, exp_e); end
  endtask

  initial begin
    test_reset();
    test_writeback_read();
    test_bypass();
    test_x0();
    test_imm();
    test_flush();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
